// File: rtl/dcache.sv
// Direct-mapped, write-back / write-allocate data cache. Misses evict a dirty
// victim beat by beat, then refill the line in beat order before the held request hits.
module dcache #(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dcen_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        dhit_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS - WORD_BITS;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS - 1);
  localparam logic [WORD_BITS-1:0] ONE_BEAT  = WORD_BITS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  beat_q, beat_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;

  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES][WORDS];

  logic [TAG_BITS-1:0]   req_tag_s;
  logic [INDEX_BITS-1:0] req_idx_s;
  logic [WORD_BITS-1:0]  req_word_s;
  logic                  hit_s;
  logic                  data_we_s;
  logic [INDEX_BITS-1:0] data_idx_s;
  logic [WORD_BITS-1:0]  data_word_s;
  logic [31:0]           data_wdata_s;
  logic                  tag_we_s;
  logic                  unused_addr_s;

  assign req_tag_s     = addr_i[31 -: TAG_BITS];
  assign req_idx_s     = addr_i[WORD_BITS+2 +: INDEX_BITS];
  assign req_word_s    = addr_i[2 +: WORD_BITS];
  assign unused_addr_s = ^addr_i[1:0];
  assign hit_s         = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);

  // State register and line status bits; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (data_we_s) begin
      data_q[data_idx_s][data_word_s] <= data_wdata_s;
    end
    if (tag_we_s) begin
      tag_q[miss_idx_q] <= miss_tag_q;
    end
  end

  // Next-state logic and the single array write port.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    data_we_s    = 1'b0;
    data_idx_s   = req_idx_s;
    data_word_s  = req_word_s;
    data_wdata_s = wdata_i;
    tag_we_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dcen_i && hit_s) begin
          if (memwrite_i) begin
            data_we_s          = 1'b1;
            dirty_d[req_idx_s] = 1'b1;
          end else begin
            data_we_s = 1'b0;
          end
        end else if (dcen_i) begin
          miss_tag_d = req_tag_s;
          miss_idx_d = req_idx_s;
          beat_d     = '0;
          if (valid_q[req_idx_s] && dirty_q[req_idx_s]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = REFILL;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + ONE_BEAT;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      REFILL: begin
        if (mem_ready_i) begin
          data_we_s    = 1'b1;
          data_idx_s   = miss_idx_q;
          data_word_s  = beat_q;
          data_wdata_s = mem_rdata_i;
          if (beat_q == LAST_BEAT) begin
            // Line becomes valid only once every beat has landed.
            tag_we_s            = 1'b1;
            valid_d[miss_idx_q] = 1'b1;
            dirty_d[miss_idx_q] = 1'b0;
            state_d             = IDLE;
            beat_d              = '0;
          end else begin
            beat_d = beat_q + ONE_BEAT;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs: CPU hit path is zero-wait; memory port is decoded from registered state.
  always_comb begin
    dhit_o      = !dcen_i || ((state_q == IDLE) && hit_s);
    rdata_o     = data_q[req_idx_s][req_word_s];
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0000_0000;
    mem_wdata_o = 32'h0000_0000;
    case (state_q)
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[miss_idx_q], miss_idx_q, beat_q, 2'b00};
        mem_wdata_o = data_q[miss_idx_q][beat_q];
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

endmodule
